// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN output-layer monitors.
//   mon_state_t   : monitor FSM encoding (IDLE=0, RUN=1, DONE=2)
//   NOUT_DEFAULT  : number of scored output neurons
//   TC_DEFAULT    : training cases per epoch
//   count_width() : register width able to hold values 0..max_val
package dnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mon_state_t;

    localparam int NOUT_DEFAULT = 10;
    localparam int TC_DEFAULT   = 12544;

    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ideal_delay_line.sv
// Delays the ideal answer vector so it lines up with the network output.
// Each stage holds a vector plus a valid bit; the line advances only when
// shift is high. DEPTH=0 is a plain pass-through that is always valid.
//   cycle_clk  : clock
//   reset      : synchronous, active-low; clears all valid bits
//   shift      : advance the line by one stage
//   din        : vector entering the line
//   dout       : oldest vector in the line
//   dout_valid : dout holds a real case
module ideal_delay_line #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         cycle_clk,
    input  logic         reset,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         dout_valid
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = cycle_clk ^ reset ^ shift;
            assign dout        = din;
            assign dout_valid  = 1'b1;
        end else begin : g_line
            logic [W-1:0] data [DEPTH];
            logic [DEPTH-1:0] vld;

            always_ff @(posedge cycle_clk) begin
                if (!reset) begin
                    vld <= '0;
                    for (int i = 0; i < DEPTH; i++) data[i] <= '0;
                end else if (shift) begin
                    data[0] <= din;
                    vld[0]  <= 1'b1;
                    for (int i = 1; i < DEPTH; i++) begin
                        data[i] <= data[i-1];
                        vld[i]  <= vld[i-1];
                    end
                end
            end

            assign dout       = data[DEPTH-1];
            assign dout_valid = vld[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/accuracy_monitor.sv
// Scores thresholded network outputs against delayed one-hot ideal answers,
// accumulating correct and ambiguous counts over windows of TC cases, for
// EPOCHS windows, then stops.
//   cycle_clk   : clock
//   reset       : synchronous, active-low
//   en          : a new case is presented this cycle
//   ans_alln    : ideal one-hot answer of the case entering the network
//   actL_alln   : network output of the case from LAT en-cycles earlier
//   run_correct : correct count so far in the current window
//   win_correct : correct count of the last completed window
//   win_ambig   : ambiguous (popcount != 1) count of the last window
//   win_done    : one-cycle pulse after a window closes
//   epoch_cnt   : completed windows
//   state       : FSM state (IDLE=0, RUN=1, DONE=2)
module accuracy_monitor
    import dnn_pkg::*;
#(
    parameter int NN     = 32,
    parameter int NOUT   = NOUT_DEFAULT,
    parameter int TC     = TC_DEFAULT,
    parameter int EPOCHS = 10,
    parameter int LAT    = 2,
    localparam int CW    = count_width(TC),
    localparam int EW    = count_width(EPOCHS)
) (
    input  logic          cycle_clk,
    input  logic          reset,
    input  logic          en,
    input  logic [NN-1:0] ans_alln,
    input  logic [NN-1:0] actL_alln,
    output logic [CW-1:0] run_correct,
    output logic [CW-1:0] win_correct,
    output logic [CW-1:0] win_ambig,
    output logic          win_done,
    output logic [EW-1:0] epoch_cnt,
    output logic [1:0]    state
);

    mon_state_t    st;
    logic [CW-1:0] case_cnt;
    logic [CW-1:0] run_ambig;

    logic [NN-1:0] ideal_d;
    logic          ideal_valid;
    logic          shift;
    logic          score;
    logic          wrap;
    logic          is_correct;
    logic          is_ambig;

    // The IDLE->RUN en cycle already feeds the delay line, so shifting is
    // gated only by DONE.
    assign shift = en && (st != ST_DONE);

    ideal_delay_line #(
        .W     (NN),
        .DEPTH (LAT)
    ) u_delay (
        .cycle_clk  (cycle_clk),
        .reset      (reset),
        .shift      (shift),
        .din        (ans_alln),
        .dout       (ideal_d),
        .dout_valid (ideal_valid)
    );

    // Only the leading NOUT neurons are scored.
    generate
        if (NOUT < NN) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^{actL_alln[NN-1:NOUT], ideal_d[NN-1:NOUT]};
        end
    endgenerate

    assign is_correct = (actL_alln[NOUT-1:0] == ideal_d[NOUT-1:0]);
    assign is_ambig   = ($countones(actL_alln[NOUT-1:0]) != 1);
    assign score      = shift && ideal_valid;
    assign wrap       = score && (case_cnt == CW'(TC - 1));

    always_ff @(posedge cycle_clk) begin
        if (!reset) begin
            st          <= ST_IDLE;
            case_cnt    <= '0;
            run_correct <= '0;
            run_ambig   <= '0;
            win_correct <= '0;
            win_ambig   <= '0;
            epoch_cnt   <= '0;
            win_done    <= 1'b0;
        end else begin
            win_done <= 1'b0;

            case (st)
                ST_IDLE: if (en) st <= ST_RUN;
                ST_RUN:  ;
                ST_DONE: ;
                default: st <= ST_IDLE;
            endcase

            // Placed after the state case so a wrap into DONE wins.
            if (score) begin
                if (wrap) begin
                    case_cnt    <= '0;
                    win_correct <= run_correct + CW'(is_correct);
                    win_ambig   <= run_ambig + CW'(is_ambig);
                    run_correct <= '0;
                    run_ambig   <= '0;
                    epoch_cnt   <= epoch_cnt + 1'b1;
                    win_done    <= 1'b1;
                    if (epoch_cnt == EW'(EPOCHS - 1)) st <= ST_DONE;
                end else begin
                    case_cnt    <= case_cnt + 1'b1;
                    run_correct <= run_correct + CW'(is_correct);
                    run_ambig   <= run_ambig + CW'(is_ambig);
                end
            end
        end
    end

    assign state = st;

endmodule
